// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clock_div_bank clock generator.
// Holds the per-channel state encoding, the tick counter width and the
// divisor arithmetic used by every channel.
package clkgen_pkg;

    localparam int TICKW = 16;

    typedef enum logic {
        CH_OFF = 1'b0,
        CH_RUN = 1'b1
    } ch_state_e;

    // A divisor below 2 cannot produce a clock, so it is promoted to 2.
    function automatic logic [31:0] eff_div(input logic [31:0] n);
        return (n < 32'd2) ? 32'd2 : n;
    endfunction

    // Length of the high phase, ceil(n/2), computed without overflowing n+1.
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One divided-clock channel: period counter, OFF/RUN state machine,
// staged reset release and, when CLKGEN_TICK_CNT_EN is defined, a
// 16-bit count of generated clock pulses.
// A new divisor is only loaded while OFF or on the last cycle of a
// period, so clk_out never produces a runt high or low phase.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int DIVW       = 8,
    parameter int RST_STAGES = 3,
    parameter int DIV_RST    = 2
) (
    input  logic             pll_clk,
    input  logic             resetb,
    input  logic             ext_reset,
    input  logic             ch_en,
    input  logic             pending,
    input  logic [DIVW-1:0]  shadow,
    output logic             apply,
    output logic             clk_out,
    output logic             clk_pulse,
    output logic             rst_out_b,
    output logic             ch_locked
`ifdef CLKGEN_TICK_CNT_EN
    ,
    output logic [TICKW-1:0] tick_cnt
`endif
);

    localparam logic [3:0]      RST_TGT  = 4'(RST_STAGES);
    localparam logic [DIVW-1:0] DIV_INIT = DIVW'(eff_div(32'(DIV_RST)));

    ch_state_e       state;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div;
    logic [DIVW-1:0] cnt_inc;
    logic [DIVW-1:0] hi;
    logic [DIVW-1:0] new_div;
    logic [3:0]      rst_cnt;
    logic [3:0]      rst_cnt_next;
    logic            terminal;
    logic            leaving;

    // Period boundary detection, divisor load decision and reset-stage counting.
    always_comb begin
        cnt_inc      = cnt + DIVW'(1);
        hi           = DIVW'(hi_len(32'(div)));
        new_div      = DIVW'(eff_div(32'(shadow)));
        terminal     = (state == CH_RUN) && (cnt == div - DIVW'(1));
        apply        = pending && ((state == CH_OFF) || terminal);
        leaving      = terminal && !ch_en;
        rst_cnt_next = rst_cnt;
        if (ext_reset || leaving || (state == CH_OFF)) begin
            rst_cnt_next = '0;
        end else if (clk_pulse && (rst_cnt != RST_TGT)) begin
            rst_cnt_next = rst_cnt + 4'd1;
        end
    end

    // Channel state machine with registered clock, strobe and reset outputs.
    always_ff @(posedge pll_clk) begin
        if (!resetb) begin
            state     <= CH_OFF;
            cnt       <= '0;
            div       <= DIV_INIT;
            clk_out   <= 1'b0;
            clk_pulse <= 1'b0;
            rst_cnt   <= '0;
            rst_out_b <= 1'b0;
        end else begin
            rst_cnt   <= rst_cnt_next;
            rst_out_b <= (rst_cnt_next == RST_TGT);
            if (apply) begin
                div <= new_div;
            end
            case (state)
                CH_OFF: begin
                    cnt <= '0;
                    if (ch_en) begin
                        state     <= CH_RUN;
                        clk_out   <= 1'b1;
                        clk_pulse <= 1'b1;
                    end else begin
                        clk_out   <= 1'b0;
                        clk_pulse <= 1'b0;
                    end
                end
                CH_RUN: begin
                    if (terminal) begin
                        cnt <= '0;
                        if (ch_en) begin
                            clk_out   <= 1'b1;
                            clk_pulse <= 1'b1;
                        end else begin
                            state     <= CH_OFF;
                            clk_out   <= 1'b0;
                            clk_pulse <= 1'b0;
                        end
                    end else begin
                        cnt       <= cnt_inc;
                        clk_out   <= (cnt_inc < hi);
                        clk_pulse <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ch_locked = (state == CH_RUN) && rst_out_b;

`ifdef CLKGEN_TICK_CNT_EN
    // Free-running count of clock pulses; holds while the channel is off.
    always_ff @(posedge pll_clk) begin
        if (!resetb) begin
            tick_cnt <= '0;
        end else if ((state == CH_RUN) && clk_pulse) begin
            tick_cnt <= tick_cnt + TICKW'(1);
        end
    end
`endif

endmodule

// File: rtl/clock_div_bank.sv
// Multi-channel programmable clock generator, fully synchronous to pll_clk.
// Holds the configuration shadow register and per-channel pending flags;
// each channel picks up the shadow divisor at its own next safe boundary.
// Optional feature: define CLKGEN_TICK_CNT_EN to add the tick_cnt output.
module clock_div_bank
    import clkgen_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DIVW       = 8,
    parameter int RST_STAGES = 3,
    parameter int DIV_RST    = 2
) (
    input  logic                 pll_clk,
    input  logic                 resetb,
    input  logic                 ext_reset,
    input  logic [NCH*DIVW-1:0]  div_cfg,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       clk_pulse,
    output logic [NCH-1:0]       rst_out_b,
    output logic [NCH-1:0]       ch_locked
`ifdef CLKGEN_TICK_CNT_EN
    ,
    output logic [NCH*TICKW-1:0] tick_cnt
`endif
);

    logic [NCH*DIVW-1:0] shadow;
    logic [NCH-1:0]      pending;
    logic [NCH-1:0]      apply;
    logic                transfer;

    assign cfg_ready = ~|pending;
    assign transfer  = cfg_valid && cfg_ready;

    // Capture a new configuration and track which channels still have to load it.
    always_ff @(posedge pll_clk) begin
        if (!resetb) begin
            shadow  <= '0;
            pending <= '0;
        end else if (transfer) begin
            shadow  <= div_cfg;
            pending <= '1;
        end else begin
            pending <= pending & ~apply;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clkgen_channel #(
            .DIVW       (DIVW),
            .RST_STAGES (RST_STAGES),
            .DIV_RST    (DIV_RST)
        ) u_ch (
            .pll_clk   (pll_clk),
            .resetb    (resetb),
            .ext_reset (ext_reset),
            .ch_en     (ch_en[i]),
            .pending   (pending[i]),
            .shadow    (shadow[i*DIVW +: DIVW]),
            .apply     (apply[i]),
            .clk_out   (clk_out[i]),
            .clk_pulse (clk_pulse[i]),
            .rst_out_b (rst_out_b[i]),
            .ch_locked (ch_locked[i])
`ifdef CLKGEN_TICK_CNT_EN
            ,
            .tick_cnt  (tick_cnt[i*TICKW +: TICKW])
`endif
        );
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Bench for clock_div_bank (NCH=4, DIVW=8, RST_STAGES=3, DIV_RST=2).
// A cycle-by-cycle vector table drives channel 0 through start-up,
// divisor changes and disable; hand-written sequences cover ext_reset
// and mid-period resetb on all channels. Builds with or without
// CLKGEN_TICK_CNT_EN.
module tb_clock_div_bank;

    logic        pll_clk;
    logic        resetb;
    logic        ext_reset;
    logic [31:0] div_cfg;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  ch_en;
    logic [3:0]  clk_out;
    logic [3:0]  clk_pulse;
    logic [3:0]  rst_out_b;
    logic [3:0]  ch_locked;
`ifdef CLKGEN_TICK_CNT_EN
    logic [63:0] tick_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    typedef struct {
        logic       rstb;
        logic       ext;
        logic       cv;
        logic [7:0] div0;
        logic       en0;
        logic       clk;
        logic       pls;
        logic       rob;
        logic       lck;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    clock_div_bank dut (
        .pll_clk   (pll_clk),
        .resetb    (resetb),
        .ext_reset (ext_reset),
        .div_cfg   (div_cfg),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ch_en     (ch_en),
        .clk_out   (clk_out),
        .clk_pulse (clk_pulse),
        .rst_out_b (rst_out_b),
        .ch_locked (ch_locked)
`ifdef CLKGEN_TICK_CNT_EN
        ,
        .tick_cnt  (tick_cnt)
`endif
    );

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge pll_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input int rstb, input int ext, input int cv, input int d, input int en,
                       input int clk, input int pls, input int rob, input int lck, input int rdy);
        vec_t v;
        v.rstb = 1'(rstb);
        v.ext  = 1'(ext);
        v.cv   = 1'(cv);
        v.div0 = 8'(d);
        v.en0  = 1'(en);
        v.clk  = 1'(clk);
        v.pls  = 1'(pls);
        v.rob  = 1'(rob);
        v.lck  = 1'(lck);
        v.rdy  = 1'(rdy);
        tbl.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        resetb    = v.rstb;
        ext_reset = v.ext;
        cfg_valid = v.cv;
        div_cfg   = {24'd0, v.div0};
        ch_en     = {3'b000, v.en0};
    endtask

    // Counts pulses and high cycles over 60 samples (a multiple of every divisor in use);
    // optionally checks that rst_out_b releases right after the third observed pulse.
    task automatic run_window(input string tag, input bit track_release);
        int pulses[4];
        int highs[4];
        int seen[4];
        int exp_p[4] = '{30, 20, 15, 12};
        int exp_h[4] = '{30, 40, 30, 36};
        for (int k = 0; k < 4; k++) begin
            pulses[k] = 0;
            highs[k]  = 0;
            seen[k]   = 0;
        end
        for (int c = 0; c < 60; c++) begin
            if (c > 0) step();
            for (int k = 0; k < 4; k++) begin
                if (track_release)
                    check_output($sformatf("%s rst_out_b ch%0d cyc%0d", tag, k, c),
                                 64'(rst_out_b[k]), 64'(seen[k] >= 3));
                if (clk_pulse[k] === 1'b1) begin
                    pulses[k]++;
                    seen[k]++;
                end
                if (clk_out[k] === 1'b1) highs[k]++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("%s pulses ch%0d", tag, k), 64'(pulses[k]), 64'(exp_p[k]));
            check_output($sformatf("%s high ch%0d", tag, k), 64'(highs[k]), 64'(exp_h[k]));
        end
    endtask

    initial begin
        resetb    = 1'b0;
        ext_reset = 1'b0;
        cfg_valid = 1'b0;
        div_cfg   = '0;
        ch_en     = '0;

        //   rstb ext cv div en | clk pls rob lck rdy
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(1, 0, 1, 4, 0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 4, 0,  0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1,  1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1,  1, 0, 1, 1, 1);
        add(1, 0, 0, 0, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 1,  0, 0, 1, 1, 1);
        add(1, 0, 1, 3, 1,  1, 1, 1, 1, 0);
        add(1, 0, 0, 3, 1,  1, 0, 1, 1, 0);
        add(1, 0, 0, 3, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 3, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 3, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 3, 1,  1, 0, 1, 1, 1);
        add(1, 0, 0, 3, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 3, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 3, 1,  1, 0, 1, 1, 1);
        add(1, 0, 0, 3, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 3, 1,  1, 1, 1, 1, 1);
        add(1, 0, 1, 0, 1,  1, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 0, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 1,  1, 1, 1, 1, 1);
        add(1, 0, 1, 1, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 1, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 1, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 1, 1,  1, 1, 1, 1, 1);
        add(1, 0, 1, 4, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 4, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 4, 1,  1, 0, 1, 1, 1);
        add(1, 0, 1, 6, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 6, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 6, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 6, 1,  1, 0, 1, 1, 1);
        add(1, 0, 0, 6, 1,  1, 0, 1, 1, 1);
        add(1, 0, 0, 6, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 6, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 6, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 6, 1,  1, 1, 1, 1, 1);
        add(1, 0, 1, 4, 1,  1, 0, 1, 1, 0);
        add(1, 0, 0, 4, 1,  1, 0, 1, 1, 0);
        add(1, 0, 0, 4, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 4, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 4, 1,  0, 0, 1, 1, 0);
        add(1, 0, 0, 4, 1,  1, 1, 1, 1, 1);
        add(1, 0, 0, 4, 1,  1, 0, 1, 1, 1);
        add(1, 0, 0, 4, 0,  0, 0, 1, 1, 1);
        add(1, 0, 0, 4, 1,  0, 0, 1, 1, 1);
        add(1, 0, 0, 4, 0,  0, 0, 0, 0, 1);
        add(1, 0, 0, 4, 0,  0, 0, 0, 0, 1);
        add(1, 0, 0, 4, 1,  1, 1, 0, 0, 1);
        add(1, 0, 0, 4, 1,  1, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            step();
            check_output($sformatf("vec%0d clk_out0", i),   64'(clk_out[0]),   64'(tbl[i].clk));
            check_output($sformatf("vec%0d clk_pulse0", i), 64'(clk_pulse[0]), 64'(tbl[i].pls));
            check_output($sformatf("vec%0d rst_out_b0", i), 64'(rst_out_b[0]), 64'(tbl[i].rob));
            check_output($sformatf("vec%0d ch_locked0", i), 64'(ch_locked[0]), 64'(tbl[i].lck));
            check_output($sformatf("vec%0d cfg_ready", i),  64'(cfg_ready),    64'(tbl[i].rdy));
            check_output($sformatf("vec%0d idle clk_out", i), 64'(clk_out[3:1]), 64'(0));
        end

        // All four channels at N=2,3,4,5, then an ext_reset pulse while locked.
        div_cfg   = {8'd5, 8'd4, 8'd3, 8'd2};
        cfg_valid = 1'b1;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin step(); n++; end
        check_output("t5 ready before transfer", 64'(cfg_ready), 64'(1));
        step();
        cfg_valid = 1'b0;
        check_output("t5 ready after capture", 64'(cfg_ready), 64'(0));
        ch_en = 4'hF;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin step(); n++; end
        check_output("t5 ready after apply", 64'(cfg_ready), 64'(1));
        n = 0;
        while (ch_locked !== 4'hF && n < 60) begin step(); n++; end
        check_output("t5 all locked", 64'(ch_locked), 64'(4'hF));
        run_window("t5 steady", 1'b0);

        ext_reset = 1'b1;
        step();
        ext_reset = 1'b0;
        check_output("t5 ext locked drop", 64'(ch_locked), 64'(0));
        run_window("t5 ext", 1'b1);
        check_output("t5 relocked", 64'(ch_locked), 64'(4'hF));

        // resetb while channel 3 (N=5) is mid-period, then restart at the reset divisor.
        n = 0;
        while (clk_pulse[3] !== 1'b1 && n < 10) begin step(); n++; end
        check_output("t6 ch3 pulse found", 64'(clk_pulse[3]), 64'(1));
        step();
        resetb = 1'b0;
        step();
        check_output("t6 rst clk_out",   64'(clk_out),   64'(0));
        check_output("t6 rst clk_pulse", 64'(clk_pulse), 64'(0));
        check_output("t6 rst rst_out_b", 64'(rst_out_b), 64'(0));
        check_output("t6 rst ch_locked", 64'(ch_locked), 64'(0));
        check_output("t6 rst cfg_ready", 64'(cfg_ready), 64'(1));
`ifdef CLKGEN_TICK_CNT_EN
        check_output("t6 rst tick_cnt", tick_cnt, 64'(0));
`endif
        resetb = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_output($sformatf("t6 clk_out k%0d", k),   64'(clk_out),   64'((k % 2 == 1) ? 4'hF : 4'h0));
            check_output($sformatf("t6 clk_pulse k%0d", k), 64'(clk_pulse), 64'((k % 2 == 1) ? 4'hF : 4'h0));
            check_output($sformatf("t6 rst_out_b k%0d", k), 64'(rst_out_b), 64'((k == 6) ? 4'hF : 4'h0));
        end
`ifdef CLKGEN_TICK_CNT_EN
        check_output("t6 tick_cnt", tick_cnt, {16'd3, 16'd3, 16'd3, 16'd3});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
